measure_collapse: RTL and testbench

MEASURE_COLLAPSE -- requirements
Module: measure_collapse

---
 rtl/measure_collapse_pkg.sv | 13 +
 rtl/measure_collapse_if.sv | 13 +
 rtl/measure_collapse_prob_calc.sv | 10 +
 rtl/measure_collapse.sv | 72 +++++++
 tb/tb_measure_collapse.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/measure_collapse_pkg.sv
// qc_pkg: shared amplitude type, fixed-point defaults and FSM state encodings
package qc_pkg;
  typedef struct packed {
    logic [7:0] re;
    logic [7:0] im;
  } complexNum;
  localparam int DEF_N = 1;
  localparam int DEF_Q = 6;
  typedef logic [1:0] fsmState;
  localparam fsmState IDLE     = 2'd0;
  localparam fsmState SCAN     = 2'd1;
  localparam fsmState COLLAPSE = 2'd2;
endpackage

// File: rtl/measure_collapse_if.sv
// measure_collapse_if: request/result bundle between a measurement requester and measure_collapse
interface measure_collapse_if import qc_pkg::*; #(parameter int N = DEF_N, parameter int Q = DEF_Q) ();
  logic start;
  logic [Q-1:0] rand_val;
  complexNum [2**N-1:0] state;
  logic busy;
  logic done;
  logic err;
  logic [N-1:0] outcome;
  complexNum [2**N-1:0] outState;
  modport master (output start, rand_val, state, input busy, done, err, outcome, outState);
  modport slave (input start, rand_val, state, output busy, done, err, outcome, outState);
endinterface

// File: rtl/measure_collapse_prob_calc.sv
// prob_calc: squared magnitude of one sign-magnitude complex amplitude, truncated to Q fractional bits
module prob_calc import qc_pkg::*; #(parameter int Q = DEF_Q) (
  input  complexNum  a,
  output logic [8:0] p
);
  logic [13:0] re2, im2;
  assign re2 = a.re[6:0] * a.re[6:0];
  assign im2 = a.im[6:0] * a.im[6:0];
  assign p = 9'((re2 >> Q) + (im2 >> Q));
endmodule

// File: rtl/measure_collapse.sv
// measure_collapse: projective measurement of a 2**N amplitude state; MEASURE_LFSR_EN selects an internal LFSR threshold
module measure_collapse import qc_pkg::*; #(parameter int N = DEF_N, parameter int Q = DEF_Q) (
  input logic clk,
  input logic rst,
  measure_collapse_if.slave bus
);
  localparam int M = 2**N;
  fsmState fsm;
  complexNum [M-1:0] st;
  logic [Q-1:0] thr, thrSrc;
  logic [8+N:0] acc, cumNext;
  logic [N-1:0] idx, sel;
  logic found;
  logic [8:0] p;
  prob_calc #(.Q(Q)) uProb (.a(st[idx]), .p(p));
  assign cumNext = acc + {{N{1'b0}}, p};
  assign bus.busy = fsm != IDLE;
`ifdef MEASURE_LFSR_EN
  logic [15:0] lfsr;
  // free-running Fibonacci LFSR, taps 16,14,13,11
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr <= 16'hACE1;
    else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign thrSrc = lfsr[Q-1:0];
`else
  assign thrSrc = bus.rand_val;
`endif
  // latch on start, scan every index for constant latency, then register the collapsed state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm <= IDLE;
      st <= '0;
      thr <= '0;
      acc <= '0;
      idx <= '0;
      sel <= '0;
      found <= 1'b0;
      bus.done <= 1'b0;
      bus.err <= 1'b0;
      bus.outcome <= '0;
      bus.outState <= '0;
    end else begin
      bus.done <= 1'b0;
      case (fsm)
        IDLE: if (bus.start) begin
          st <= bus.state;
          thr <= thrSrc;
          acc <= '0;
          idx <= '0;
          sel <= '0;
          found <= 1'b0;
          fsm <= SCAN;
        end
        SCAN: begin
          acc <= cumNext;
          idx <= idx + 1'b1;
          if (!found && p != '0) sel <= idx;
          found <= found | (cumNext > {{(9+N-Q){1'b0}}, thr});
          if (&idx) fsm <= COLLAPSE;
        end
        COLLAPSE: begin
          for (int i = 0; i < M; i++) bus.outState[i] <= (i == int'(sel)) ? st[i] : '0;
          bus.outcome <= sel;
          bus.err <= acc == '0;
          bus.done <= 1'b1;
          fsm <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_measure_collapse.sv
// tb_measure_collapse: directed checks of measure_collapse for N=1 and N=2
module tb_measure_collapse;
  import qc_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int n, cnt;
  measure_collapse_if #(.N(1)) b1 ();
  measure_collapse_if #(.N(2)) b2 ();
  measure_collapse #(.N(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  measure_collapse #(.N(2)) u2 (.clk(clk), .rst(rst), .bus(b2));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait1(output int k);
    k = 0;
    while (!b1.done && k < 12) begin
      @(posedge clk); #1;
      k++;
    end
  endtask
  task automatic wait2(input int k0, output int k);
    k = k0;
    while (!b2.done && k < 14) begin
      @(posedge clk); #1;
      k++;
    end
  endtask
  task automatic go1(input logic [5:0] r, input logic [31:0] s, output int k);
    b1.rand_val = r;
    b1.state = s;
    b1.start = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0;
    wait1(k);
  endtask
  initial begin
    b1.start = 1'b0; b1.rand_val = '0; b1.state = '0;
    b2.start = 1'b0; b2.rand_val = '0; b2.state = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst1_ctl", {b1.busy, b1.done, b1.err, b1.outcome}, 0);
    chk("rst1_state", b1.outState, 0);
    chk("rst2_ctl", {b2.busy, b2.done, b2.err, b2.outcome}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    go1(6'd63, {16'h0000, 16'h4000}, n);
    chk("a_lat", n, 3);
    chk("a_outcome", b1.outcome, 0);
    chk("a_state", b1.outState, 32'h0000_4000);
    chk("a_err", b1.err, 0);
    @(posedge clk); #1;
    chk("a_pulse", b1.done, 0);
    b1.rand_val = 6'd10;
    b1.state = {16'h2D00, 16'h2D00};
    b1.start = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0;
    b1.rand_val = 6'd40;
    b1.state = '0;
    chk("b_busy", b1.busy, 1);
    wait1(n);
    chk("b_lat", n, 3);
    chk("b_outcome", b1.outcome, 0);
    chk("b_state", b1.outState, 32'h0000_2D00);
    go1(6'd40, {16'h2D00, 16'h2D00}, n);
    chk("c_b2b_lat", n, 3);
    chk("c_outcome", b1.outcome, 1);
    chk("c_state", b1.outState, 32'h2D00_0000);
    go1(6'd63, {16'h2D00, 16'h2D00}, n);
    chk("d_fallback", b1.outcome, 1);
    chk("d_err", b1.err, 0);
    go1(6'd5, 32'h0, n);
    chk("e_lat", n, 3);
    chk("e_err", b1.err, 1);
    chk("e_outcome", b1.outcome, 0);
    chk("e_state", b1.outState, 0);
    cnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      cnt += int'(b1.done);
    end
    chk("e_once", cnt, 0);
    chk("e_hold", b1.err, 1);
    b2.rand_val = 6'd17;
    b2.state = {16'h0000, 16'h00C0, 16'h0000, 16'h0000};
    b2.start = 1'b1;
    @(posedge clk); #1;
    b2.start = 1'b0;
    @(posedge clk); #1;
    b2.start = 1'b1;
    chk("f_busy", b2.busy, 1);
    @(posedge clk); #1;
    b2.start = 1'b0;
    wait2(2, n);
    chk("f_lat", n, 5);
    chk("f_outcome", b2.outcome, 2);
    chk("f_state", b2.outState, 64'h0000_00C0_0000_0000);
    chk("f_err", b2.err, 0);
    cnt = 0;
    repeat (8) begin
      @(posedge clk); #1;
      cnt += int'(b2.done);
    end
    chk("f_ignored", cnt, 0);
    b2.start = 1'b1;
    @(posedge clk); #1;
    b2.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("g_rst_state", b2.outState, 0);
    chk("g_rst_ctl", {b2.busy, b2.done, b2.err, b2.outcome}, 0);
    chk("g_rst_n1", {b1.err, b1.outState}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(posedge clk); #1;
      cnt += int'(b2.done);
    end
    chk("g_no_done", cnt, 0);
    b2.rand_val = 6'd63;
    b2.state = {16'h4000, 16'h0000, 16'h4000, 16'h0000};
    b2.start = 1'b1;
    @(posedge clk); #1;
    b2.start = 1'b0;
    wait2(0, n);
    chk("h_lat", n, 5);
    chk("h_outcome", b2.outcome, 1);
    chk("h_state", b2.outState, 64'h0000_0000_4000_0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
